// File: rtl/iir_decim_pkg.sv
// Shared constants and helpers for the IIR output stage.
// Holds the sample width shared with the filter, the default decimation and the rounding offset.
package iir_decim_pkg;

    localparam int SAMPLE_W  = 14;
    localparam int LOG2R_DEF = 2;

    function automatic int round_ofs(input int log2r);
        return 1 << (log2r - 1);
    endfunction

endpackage

// File: rtl/iir_sync_fifo.sv
// Synchronous FIFO with combinational head read; output is 0 while empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module iir_sync_fifo #(
    parameter int DW = 15,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] PTR_ONE = 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/iir_decim.sv
// Integrate-and-dump decimator by 2**LOG2R with round-half-up, feeding a small output FIFO.
// Latency: result visible the cycle after the R-th accepted sample; full FIFO without pop drops it and sets ovf.
module iir_decim
    import iir_decim_pkg::*;
#(
    parameter int W          = SAMPLE_W,
    parameter int LOG2R      = LOG2R_DEF,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W:0]   x_in,
    input  logic                x_valid,
    output logic signed [W:0]   y_out,
    output logic                y_valid,
    input  logic                y_ready,
    output logic [DEPTH_LOG2:0] level,
    output logic                ovf,
    input  logic                ovf_clr
);

    localparam int AW = W + 1 + LOG2R;
    localparam logic signed [AW-1:0] OFS     = AW'(round_ofs(LOG2R));
    localparam logic [LOG2R-1:0]     PH_LAST = '1;
    localparam logic [LOG2R-1:0]     PH_ONE  = 1;

    logic signed [AW-1:0] acc_q, acc_d;
    logic [LOG2R-1:0]     phase_q, phase_d;
    logic                 ovf_q, ovf_d;
    logic signed [AW-1:0] x_ext, sum, rnd;
    logic [W:0]           dec;
    logic [LOG2R-1:0]     rnd_frac;
    logic [W:0]           fifo_dout;
    logic                 dump, pop, full, empty, drop;

    assign x_ext = {{LOG2R{x_in[W]}}, x_in};
    assign sum   = acc_q + x_ext;
    assign rnd   = sum + OFS;
    // Dropping the low LOG2R bits is the arithmetic shift, truncated to the sample width.
    assign {dec, rnd_frac} = rnd;

    always_comb begin
        acc_d   = acc_q;
        phase_d = phase_q;
        dump    = 1'b0;
        if (x_valid) begin
            if (phase_q == PH_LAST) begin
                dump    = 1'b1;
                acc_d   = '0;
                phase_d = '0;
            end else begin
                acc_d   = sum;
                phase_d = phase_q + PH_ONE;
            end
        end
    end

    assign y_valid = ~empty;
    assign pop     = y_valid & y_ready;
    assign drop    = dump & full & ~pop;
    assign y_out   = fifo_dout;
    assign ovf     = ovf_q;

    // A fresh overflow beats a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            phase_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            phase_q <= phase_d;
            ovf_q   <= ovf_d;
        end
    end

    iir_sync_fifo #(
        .DW (W + 1),
        .AW (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (dump),
        .pop   (pop),
        .din   (dec),
        .dout  (fifo_dout),
        .level (level),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_iir_decim.sv
// Directed and random checks of iir_decim against a sample-list / queue reference model.
module tb_iir_decim;

    localparam int R     = 4;
    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [14:0] x_in = '0;
    logic               x_valid = 1'b0;
    logic signed [14:0] y_out;
    logic               y_valid;
    logic               y_ready = 1'b0;
    logic [2:0]         level;
    logic               ovf;
    logic               ovf_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    int samp[$];
    int mq[$];
    int got[$];
    bit m_ovf = 1'b0;
    int vcount = 0;

    always #5 clk = ~clk;

    iir_decim dut (
        .clk     (clk),
        .reset   (reset),
        .x_in    (x_in),
        .x_valid (x_valid),
        .y_out   (y_out),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .level   (level),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int floor_div(input int n, input int d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    task automatic check_outputs();
        int exp_y;
        exp_y = (mq.size() != 0) ? mq[0] : 0;
        check("y_valid", {31'd0, y_valid}, (mq.size() != 0) ? 1 : 0);
        check("y_out", y_out, exp_y);
        check("level", {29'd0, level}, mq.size());
        check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    endtask

    task automatic step(input bit xv, input int x, input bit yr, input bit clr);
        bit pop_m, full_m, drop_m;
        int sum;
        reset   = 1'b0;
        x_valid = xv;
        x_in    = 15'(x);
        y_ready = yr;
        ovf_clr = clr;
        #1;
        if (y_valid) vcount++;
        if (y_valid && yr) got.push_back(int'(y_out));
        pop_m  = (mq.size() != 0) && yr;
        full_m = (mq.size() == DEPTH);
        drop_m = 1'b0;
        @(posedge clk);
        if (pop_m) void'(mq.pop_front());
        if (xv) begin
            samp.push_back(x);
            if (samp.size() == R) begin
                sum = 0;
                foreach (samp[i]) sum += samp[i];
                samp.delete();
                if (!full_m || pop_m) mq.push_back(floor_div(sum + R / 2, R));
                else drop_m = 1'b1;
            end
        end
        if (drop_m) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        x_valid = 1'b1;
        x_in    = 15'sd1000;
        y_ready = 1'b1;
        ovf_clr = 1'b0;
        @(posedge clk);
        samp.delete();
        mq.delete();
        m_ovf = 1'b0;
        #1;
        check("rst_y_valid", {31'd0, y_valid}, 0);
        check("rst_y_out", y_out, 0);
        check("rst_level", {29'd0, level}, 0);
        check("rst_ovf", {31'd0, ovf}, 0);
    endtask

    initial begin
        do_reset();
        do_reset();

        // Basic average
        got.delete(); vcount = 0;
        for (int i = 0; i < 4; i++) step(1, 100 + i, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        check("avg_count", got.size(), 1);
        check("avg_value", got[0], 102);
        check("avg_valid_cycles", vcount, 1);
        check("avg_level", {29'd0, level}, 0);

        // Rounding and extremes
        got.delete();
        step(1, -1, 1, 0); step(1, -2, 1, 0); step(1, -2, 1, 0); step(1, -2, 1, 0);
        step(1, -1, 1, 0); step(1, -1, 1, 0); step(1, -1, 1, 0); step(1, -3, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 16383, 1, 0);
        for (int i = 0; i < 4; i++) step(1, -16384, 1, 0);
        step(0, 0, 1, 0); step(0, 0, 1, 0);
        check("rnd_count", got.size(), 4);
        check("rnd_neg", got[0], -2);
        check("rnd_half_up", got[1], -1);
        check("rnd_max", got[2], 16383);
        check("rnd_min", got[3], -16384);

        // Overflow with stalled consumer
        got.delete();
        for (int i = 0; i < 20; i++) step(1, 8, 0, 0);
        check("ovf_level", {29'd0, level}, 4);
        check("ovf_set", {31'd0, ovf}, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
        check("ovf_drain_count", got.size(), 4);
        foreach (got[i]) check("ovf_drain_val", got[i], 8);
        check("ovf_sticky", {31'd0, ovf}, 1);
        step(0, 0, 1, 1);
        check("ovf_cleared", {31'd0, ovf}, 0);

        // Full FIFO with pop on the dump cycle
        got.delete();
        for (int k = 1; k <= 4; k++)
            for (int i = 0; i < 4; i++) step(1, 10 * k, 0, 0);
        check("full_level", {29'd0, level}, 4);
        for (int i = 0; i < 3; i++) step(1, 50, 0, 0);
        step(1, 50, 1, 0);
        check("full_pop_level", {29'd0, level}, 4);
        check("full_pop_ovf", {31'd0, ovf}, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
        check("full_pop_count", got.size(), 5);
        for (int i = 0; i < 5; i++) check("full_pop_order", got[i], 10 * (i + 1));

        // Gapped input
        got.delete();
        for (int i = 0; i < 4; i++) begin
            step(1, 4 * (i + 1), 1, 0);
            step(0, 999, 1, 0);
        end
        step(0, 0, 1, 0);
        check("gap_count", got.size(), 1);
        check("gap_value", got[0], 10);

        // Reset discards partial accumulation
        got.delete();
        step(1, 1000, 1, 0); step(1, 1000, 1, 0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 8, 1, 0);
        step(0, 0, 1, 0);
        check("rst_partial_count", got.size(), 1);
        check("rst_partial_value", got[0], 8);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 32767)) - 16384,
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
